// File: rtl/memstream_pkg.sv
// memstream_pkg: shared types and width helpers for the multi-set parameter
// streamer (memstream_sets) and its output buffer (memstream_obuf).
//   addr_t(n)   : bits needed to index n items, never less than 1
//   set_bits(n) : width of the set-select token for n sets
//   op_e        : operation occupying the single RAM issue slot in a cycle
//   state_e     : stream sequencer states
package memstream_pkg;

  function automatic int addr_t(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int set_bits(input int nsets);
    return addr_t(nsets);
  endfunction

  typedef enum logic [1:0] {
    OP_NONE,
    OP_WR,
    OP_RB,
    OP_RS
  } op_e;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

endpackage

// File: rtl/memstream_obuf.sv
// memstream_obuf: small FIFO of {last, data} words sitting between the RAM
// read pipeline and the stream output.
//   clk, rst_n          : clock, asynchronous active-low reset (empties FIFO)
//   push_i, pushLast_i,
//   pushData_i          : word arriving from the RAM read pipeline
//   pop_i               : head word consumed this cycle
//   vld_o, last_o,
//   data_o              : head word; last_o is forced low while empty
//   count_o             : current occupancy, used for read-credit accounting
module memstream_obuf
  import memstream_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pushLast_i,
  input  logic [WIDTH-1:0]           pushData_i,
  input  logic                       pop_i,
  output logic                       vld_o,
  output logic                       last_o,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = addr_t(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH:0]  store [DEPTH];
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            doPush, doPop;
  logic [WIDTH:0]  head;

  function automatic logic [PW-1:0] wrapInc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full buffer is still taken when the head leaves in the same
  // cycle, so occupancy never drifts on simultaneous push/pop.
  assign doPop  = pop_i && (count_q != '0);
  assign doPush = push_i && ((count_q != CW'(DEPTH)) || doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrapInc(wrPtr_q);
    if (doPop)  rdPtr_d = wrapInc(rdPtr_q);
    count_d = count_q + CW'(doPush) - CW'(doPop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) store[wrPtr_q] <= {pushLast_i, pushData_i};
  end

  assign head    = store[rdPtr_q];
  assign vld_o   = (count_q != '0);
  assign last_o  = vld_o && head[WIDTH];
  assign data_o  = head[WIDTH-1:0];
  assign count_o = count_q;

endmodule

// File: rtl/memstream_sets.sv
// memstream_sets: holds NSETS parameter sets of DEPTH words in one RAM and
// streams one full pass of a selected set per accepted token.
//   clk, rst_n            : clock, asynchronous active-low reset
//   config_ce/we/address/
//   config_d0             : configuration write or readback request
//   config_rack, config_q0: readback valid pulse and data, 2 cycles after ce
//   set_vld/set_rdy/set_dat: set-select token handshake
//   ordy/ovld/odat/olast  : output stream, olast marks the final word of a pass
// Stream reads are only issued while the output buffer has room for every
// read still in flight, so readback latency never depends on ordy.
module memstream_sets
  import memstream_pkg::*;
#(
  parameter int    DEPTH      = 2,
  parameter int    WIDTH      = 32,
  parameter int    NSETS      = 1,
  parameter int    OBUF_DEPTH = 4,
  parameter string INIT_FILE  = "",
  parameter string RAM_STYLE  = "auto"
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       config_ce,
  input  logic                       config_we,
  input  logic [31:0]                config_address,
  input  logic [WIDTH-1:0]           config_d0,
  output logic                       config_rack,
  output logic [WIDTH-1:0]           config_q0,
  input  logic                       set_vld,
  output logic                       set_rdy,
  input  logic [set_bits(NSETS)-1:0] set_dat,
  input  logic                       ordy,
  output logic                       ovld,
  output logic [WIDTH-1:0]           odat,
  output logic                       olast
);

  localparam int TOTAL = NSETS * DEPTH;
  localparam int AW    = addr_t(TOTAL);
  localparam int PW    = addr_t(DEPTH);
  localparam int CW    = $clog2(OBUF_DEPTH + 1);

  (* ram_style = RAM_STYLE *) logic [WIDTH-1:0] mem [TOTAL];

  state_e          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  op_e             op, op1_q;
  logic            last1_q;
  logic            rack_q;
  logic [WIDTH-1:0] memRd_q, q0_q;

  logic            cfgInRange;
  logic [AW-1:0]   streamAddr, issueAddr;
  logic            streamIssue, lastIssue, tokenRdy;
  logic            creditOk;
  logic [CW-1:0]   obufCount;
  logic [CW:0]     obufUsed;
  logic            obufPop;

  assign cfgInRange = (config_address < 32'(TOTAL));
  assign streamAddr = base_q + AW'(ptr_q);
  assign issueAddr  = config_ce ? config_address[AW-1:0] : streamAddr;

  // Credits: buffer entries plus the one read that can be between the RAM
  // and the buffer must leave a free slot before another read is issued.
  assign obufUsed = {1'b0, obufCount} + {{CW{1'b0}}, (op1_q == OP_RS)};
  assign creditOk = (obufUsed < (CW + 1)'(OBUF_DEPTH));

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    ptr_d       = ptr_q;
    streamIssue = 1'b0;
    lastIssue   = 1'b0;
    tokenRdy    = 1'b0;
    case (state_q)
      IDLE: tokenRdy = 1'b1;
      STREAM: begin
        if (!config_ce && creditOk) begin
          streamIssue = 1'b1;
          lastIssue   = (ptr_q == PW'(DEPTH - 1));
          ptr_d       = ptr_q + 1'b1;
          if (lastIssue) begin
            state_d  = IDLE;
            tokenRdy = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // The base multiply lives here, at token accept, off the issue path.
    if (tokenRdy && set_vld) begin
      if (32'(set_dat) < 32'(NSETS)) begin
        base_d  = AW'(32'(set_dat) * 32'(DEPTH));
        ptr_d   = '0;
        state_d = STREAM;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    op = OP_NONE;
    if (config_ce)        op = config_we ? OP_WR : OP_RB;
    else if (streamIssue) op = OP_RS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      ptr_q   <= '0;
      op1_q   <= OP_NONE;
      last1_q <= 1'b0;
      rack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      ptr_q   <= ptr_d;
      op1_q   <= op;
      last1_q <= lastIssue;
      rack_q  <= (op1_q == OP_RB);
    end
  end

  // Single-port RAM: one operation per cycle; out-of-range writes are dropped
  // and out-of-range readbacks leave the read register untouched.
  always_ff @(posedge clk) begin
    if (op == OP_WR && cfgInRange) mem[issueAddr] <= config_d0;
    if (op == OP_RS || (op == OP_RB && cfgInRange)) memRd_q <= mem[issueAddr];
    q0_q <= memRd_q;
  end

  assign obufPop = ovld && ordy;

  memstream_obuf #(
    .DEPTH (OBUF_DEPTH),
    .WIDTH (WIDTH)
  ) u_obuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (op1_q == OP_RS),
    .pushLast_i (last1_q),
    .pushData_i (memRd_q),
    .pop_i      (obufPop),
    .vld_o      (ovld),
    .last_o     (olast),
    .data_o     (odat),
    .count_o    (obufCount)
  );

  assign set_rdy     = tokenRdy && rst_n;
  assign config_rack = rack_q;
  assign config_q0   = q0_q;

endmodule

// File: tb/tb_memstream_sets.sv
// tb_memstream_sets: self-checking bench for memstream_sets. A queue-based
// model tracks which RAM words each accepted token must produce and which
// readbacks are due, and looks data up in a mirror of the RAM contents.
module tb_memstream_sets;

  localparam int NS  = 4;
  localparam int DP  = 3;
  localparam int W   = 8;
  localparam int TOT = NS * DP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          config_ce, config_we;
  logic [31:0]   config_address;
  logic [W-1:0]  config_d0;
  logic          config_rack;
  logic [W-1:0]  config_q0;
  logic          set_vld, set_rdy;
  logic [1:0]    set_dat;
  logic          ordy, ovld, olast;
  logic [W-1:0]  odat;

  memstream_sets #(
    .DEPTH(DP), .WIDTH(W), .NSETS(NS), .OBUF_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .config_ce(config_ce), .config_we(config_we),
    .config_address(config_address), .config_d0(config_d0),
    .config_rack(config_rack), .config_q0(config_q0),
    .set_vld(set_vld), .set_rdy(set_rdy), .set_dat(set_dat),
    .ordy(ordy), .ovld(ovld), .odat(odat), .olast(olast)
  );

  // Three-set instance so an out-of-range token fits in the 2-bit select.
  logic          c3Ce, c3We, c3Rack, c3Vld, c3Rdy, c3Ordy, c3Ovld, c3Olast;
  logic [31:0]   c3Addr;
  logic [W-1:0]  c3D0, c3Q0, c3Odat;
  logic [1:0]    c3Dat;

  memstream_sets #(
    .DEPTH(DP), .WIDTH(W), .NSETS(3), .OBUF_DEPTH(4)
  ) dut3 (
    .clk(clk), .rst_n(rst_n),
    .config_ce(c3Ce), .config_we(c3We),
    .config_address(c3Addr), .config_d0(c3D0),
    .config_rack(c3Rack), .config_q0(c3Q0),
    .set_vld(c3Vld), .set_rdy(c3Rdy), .set_dat(c3Dat),
    .ordy(c3Ordy), .ovld(c3Ovld), .odat(c3Odat), .olast(c3Olast)
  );

  typedef struct { int addr; bit last; } exp_t;
  typedef struct { int due; bit known; logic [W-1:0] dat; } rb_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  exp_t         expQ[$];
  rb_t          rbQ[$];
  int           outCyc[$];
  logic [W-1:0] ramModel [TOT];
  bit           accepted;
  int           acceptCyc;
  bit           prevStall;
  logic [W-1:0] prevDat;
  logic         prevLast;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the inputs currently driven: check outputs mid-cycle,
  // then fold this cycle's token/config activity into the model.
  task automatic applyStimulus();
    bit inR;
    @(negedge clk);
    if (rbQ.size() > 0 && rbQ[0].due == cyc) begin
      checkOutput("rack", config_rack, 1);
      if (rbQ[0].known) checkOutput("q0", config_q0, rbQ[0].dat);
      void'(rbQ.pop_front());
    end else begin
      checkOutput("rackIdle", config_rack, 0);
    end
    if (prevStall) begin
      checkOutput("holdVld", ovld, 1);
      checkOutput("holdDat", odat, prevDat);
      checkOutput("holdLast", olast, prevLast);
    end
    if (ovld === 1'b1 && ordy) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious", ovld, 0);
      end else begin
        checkOutput("odat", odat, ramModel[expQ[0].addr]);
        checkOutput("olast", olast, expQ[0].last);
        void'(expQ.pop_front());
        outCyc.push_back(cyc);
      end
    end
    prevStall = (ovld === 1'b1) && !ordy;
    prevDat   = odat;
    prevLast  = olast;
    accepted  = 0;
    if (set_vld && set_rdy === 1'b1) begin
      accepted  = 1;
      acceptCyc = cyc;
      if (int'(set_dat) < NS)
        for (int i = 0; i < DP; i++)
          expQ.push_back('{addr: int'(set_dat) * DP + i, last: (i == DP - 1)});
    end
    if (config_ce) begin
      inR = (config_address < TOT);
      if (config_we) begin
        if (inR) ramModel[config_address] = config_d0;
      end else begin
        rbQ.push_back('{due: cyc + 2, known: inR, dat: inR ? ramModel[config_address] : '0});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idleInputs();
    config_ce = 0;
    config_we = 0;
    set_vld   = 0;
    ordy      = 1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((expQ.size() > 0 || rbQ.size() > 0 || ovld === 1'b1) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput(tag, (n < budget), 1);
  endtask

  task automatic sendToken(input int s);
    int n = 0;
    set_vld = 1;
    set_dat = 2'(s);
    do begin
      applyStimulus();
      n++;
    end while (!accepted && n < 20);
    set_vld = 0;
    checkOutput("tokenAccept", accepted, 1);
  endtask

  initial begin
    int a1;
    int k;
    int firstT;
    rst_n = 0;
    idleInputs();
    config_address = 0;
    config_d0 = 0;
    set_dat = 0;
    prevStall = 0;
    c3Ce = 0; c3We = 0; c3Addr = 0; c3D0 = 0; c3Vld = 0; c3Dat = 0; c3Ordy = 1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstOvld", ovld, 0);
    checkOutput("rstOlast", olast, 0);
    checkOutput("rstRack", config_rack, 0);
    checkOutput("rstSetRdy", set_rdy, 0);
    rst_n = 1;
    #1;
    checkOutput("idleSetRdy", set_rdy, 1);

    // Load word 10*s+i, then probe the address guard and readback path.
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < DP; i++) begin
        config_ce = 1; config_we = 1;
        config_address = s * DP + i;
        config_d0 = W'(10 * s + i);
        applyStimulus();
      end
    config_address = 32'd21; config_d0 = 8'hEE; applyStimulus();
    config_address = 32'd12; config_d0 = 8'hEF; applyStimulus();
    config_we = 0;
    config_address = 32'd5;  applyStimulus();
    config_address = 32'd14; applyStimulus();
    idleInputs();
    drain("drainCfg", 10);

    // Single pass of set 2 with ordy held high.
    outCyc.delete();
    sendToken(2);
    drain("drainA", 20);
    checkOutput("aCount", outCyc.size(), 3);
    checkOutput("aLatency", outCyc[0], acceptCyc + 3);
    checkOutput("aSpan", outCyc[2] - outCyc[0], 2);

    // Back-to-back tokens must produce gapless passes.
    outCyc.delete();
    sendToken(1);
    a1 = acceptCyc;
    sendToken(3);
    checkOutput("bAcceptGap", acceptCyc - a1, DP);
    drain("drainB", 20);
    checkOutput("bCount", outCyc.size(), 6);
    checkOutput("bSpan", outCyc[5] - outCyc[0], 5);

    // Stalling output interleaved with readbacks of address 7.
    outCyc.delete();
    sendToken(0);
    for (int n = 0; n < 24; n++) begin
      case (n)
        0, 3:    ordy = 1;
        1, 2:    ordy = 0;
        default: ordy = 1'($urandom_range(0, 1));
      endcase
      config_ce = (n % 2 == 0);
      config_we = 0;
      config_address = 32'd7;
      applyStimulus();
    end
    idleInputs();
    drain("drainC", 40);
    checkOutput("cCount", outCyc.size(), 3);

    // Overwrite set 1 word 2 after the pass has started.
    outCyc.delete();
    sendToken(1);
    config_ce = 1; config_we = 1; config_address = 32'd5; config_d0 = 8'd99;
    applyStimulus();
    config_we = 0;
    applyStimulus();
    idleInputs();
    drain("drainD", 20);
    checkOutput("dCount", outCyc.size(), 3);

    // Out-of-range token on the three-set instance.
    for (int i = 0; i < DP; i++) begin
      c3Ce = 1; c3We = 1; c3Addr = i; c3D0 = W'(8'h40 + i);
      @(posedge clk); #1;
    end
    c3Ce = 0; c3We = 0;
    c3Vld = 1; c3Dat = 2'd3;
    checkOutput("oorRdy", c3Rdy, 1);
    @(posedge clk); #1;
    c3Vld = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checkOutput("oorNoVld", c3Ovld, 0);
      @(posedge clk); #1;
    end
    checkOutput("oorRdyAfter", c3Rdy, 1);
    c3Vld = 1; c3Dat = 2'd0;
    @(posedge clk); #1;
    c3Vld = 0;
    k = 0;
    firstT = -1;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      if (c3Ovld === 1'b1 && c3Ordy) begin
        if (firstT < 0) firstT = t;
        checkOutput("c3Dat", c3Odat, 8'h40 + k);
        checkOutput("c3Last", c3Olast, (k == DP - 1));
        k++;
      end
      @(posedge clk); #1;
    end
    checkOutput("c3Count", k, 3);
    checkOutput("c3Latency", firstT, 3);

    // Reset mid-pass with a full buffer and a readback in flight.
    ordy = 0;
    sendToken(2);
    sendToken(3);
    for (int n = 0; n < 7; n++) applyStimulus();
    config_ce = 1; config_we = 0; config_address = 32'd0;
    applyStimulus();
    config_ce = 0;
    checkOutput("preRstFull", ovld, 1);
    rst_n = 0;
    #1;
    checkOutput("rstMidOvld", ovld, 0);
    checkOutput("rstMidRack", config_rack, 0);
    checkOutput("rstMidOlast", olast, 0);
    expQ.delete();
    rbQ.delete();
    prevStall = 0;
    applyStimulus();
    applyStimulus();
    checkOutput("rstMidSetRdy", set_rdy, 0);
    rst_n = 1;
    #1;
    checkOutput("relSetRdy", set_rdy, 1);
    ordy = 1;
    outCyc.delete();
    sendToken(1);
    drain("drainF", 20);
    checkOutput("fCount", outCyc.size(), 3);
    checkOutput("fLatency", outCyc[0], acceptCyc + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1);
  end

endmodule
